// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions, snoops the CDB for pending
// operands and issues the lowest-index operand-complete entry to one functional unit.
module reservation_station #(
   parameter int DEPTH     = 4,
   parameter int ROB_IDX_W = 4,
   parameter int OP_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 disp_valid,
   output logic                 disp_ready,
   input  logic [OP_W-1:0]      disp_op,
   input  logic                 disp_rs1_rdy,
   input  logic [31:0]          disp_rs1_val,
   input  logic [ROB_IDX_W-1:0] disp_rs1_tag,
   input  logic                 disp_rs2_rdy,
   input  logic [31:0]          disp_rs2_val,
   input  logic [ROB_IDX_W-1:0] disp_rs2_tag,
   input  logic [ROB_IDX_W-1:0] disp_rob_idx,
   input  logic [4:0]           disp_rd_addr,
   input  logic                 cdb_valid,
   input  logic [31:0]          cdb_data,
   input  logic [ROB_IDX_W-1:0] cdb_rob_idx,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output logic [OP_W-1:0]      issue_op,
   output logic [31:0]          issue_rs1,
   output logic [31:0]          issue_rs2,
   output logic [ROB_IDX_W-1:0] issue_rob_idx,
   output logic [4:0]           issue_rd_addr
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]     busy;
   logic [DEPTH-1:0]     rs1_rdy;
   logic [DEPTH-1:0]     rs2_rdy;
   logic [OP_W-1:0]      op_q    [DEPTH];
   logic [31:0]          rs1_val [DEPTH];
   logic [31:0]          rs2_val [DEPTH];
   logic [ROB_IDX_W-1:0] rs1_tag [DEPTH];
   logic [ROB_IDX_W-1:0] rs2_tag [DEPTH];
   logic [ROB_IDX_W-1:0] rob_q   [DEPTH];
   logic [4:0]           rd_q    [DEPTH];

   logic [DEPTH-1:0] entry_rdy;
   logic [IDX_W-1:0] alloc_idx;
   logic [IDX_W-1:0] sel_idx;
   logic             disp_fire;
   logic             issue_fire;
   logic             rs1_bypass;
   logic             rs2_bypass;

   // Readiness and free slots come only from registered state, so neither the
   // CDB nor this cycle's issue can combinationally affect issue or dispatch.
   assign entry_rdy   = busy & rs1_rdy & rs2_rdy;
   assign disp_ready  = ~&busy;
   assign issue_valid = |entry_rdy;
   assign disp_fire   = disp_valid && disp_ready;
   assign issue_fire  = issue_valid && issue_ready;
   assign rs1_bypass  = !disp_rs1_rdy && cdb_valid && (cdb_rob_idx == disp_rs1_tag);
   assign rs2_bypass  = !disp_rs2_rdy && cdb_valid && (cdb_rob_idx == disp_rs2_tag);

   always_comb begin
      alloc_idx = '0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i])     alloc_idx = IDX_W'(i);
         if (entry_rdy[i]) sel_idx   = IDX_W'(i);
      end
   end

   assign issue_op      = issue_valid ? op_q[sel_idx]    : '0;
   assign issue_rs1     = issue_valid ? rs1_val[sel_idx] : '0;
   assign issue_rs2     = issue_valid ? rs2_val[sel_idx] : '0;
   assign issue_rob_idx = issue_valid ? rob_q[sel_idx]   : '0;
   assign issue_rd_addr = issue_valid ? rd_q[sel_idx]    : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy    <= '0;
         rs1_rdy <= '0;
         rs2_rdy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]    <= '0;
            rs1_val[i] <= '0;
            rs2_val[i] <= '0;
            rs1_tag[i] <= '0;
            rs2_tag[i] <= '0;
            rob_q[i]   <= '0;
            rd_q[i]    <= '0;
         end
      end else if (flush) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (busy[i]) begin
               if (!rs1_rdy[i] && cdb_valid && (cdb_rob_idx == rs1_tag[i])) begin
                  rs1_rdy[i] <= 1'b1;
                  rs1_val[i] <= cdb_data;
               end
               if (!rs2_rdy[i] && cdb_valid && (cdb_rob_idx == rs2_tag[i])) begin
                  rs2_rdy[i] <= 1'b1;
                  rs2_val[i] <= cdb_data;
               end
               if (issue_fire && (sel_idx == IDX_W'(i)))
                  busy[i] <= 1'b0;
            end else if (disp_fire && (alloc_idx == IDX_W'(i))) begin
               busy[i]    <= 1'b1;
               op_q[i]    <= disp_op;
               rs1_rdy[i] <= disp_rs1_rdy || rs1_bypass;
               rs1_val[i] <= rs1_bypass ? cdb_data : disp_rs1_val;
               rs1_tag[i] <= disp_rs1_tag;
               rs2_rdy[i] <= disp_rs2_rdy || rs2_bypass;
               rs2_val[i] <= rs2_bypass ? cdb_data : disp_rs2_val;
               rs2_tag[i] <= disp_rs2_tag;
               rob_q[i]   <= disp_rob_idx;
               rd_q[i]    <= disp_rd_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, hand-written corner
// sequences, then random traffic compared against an entry-list reference model.
module tb_reservation_station;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        disp_valid;
   logic        disp_ready;
   logic [3:0]  disp_op;
   logic        disp_rs1_rdy;
   logic [31:0] disp_rs1_val;
   logic [3:0]  disp_rs1_tag;
   logic        disp_rs2_rdy;
   logic [31:0] disp_rs2_val;
   logic [3:0]  disp_rs2_tag;
   logic [3:0]  disp_rob_idx;
   logic [4:0]  disp_rd_addr;
   logic        cdb_valid;
   logic [31:0] cdb_data;
   logic [3:0]  cdb_rob_idx;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_op;
   logic [31:0] issue_rs1;
   logic [31:0] issue_rs2;
   logic [3:0]  issue_rob_idx;
   logic [4:0]  issue_rd_addr;

   int checks = 0;
   int errors = 0;

   reservation_station #(.DEPTH(4), .ROB_IDX_W(4), .OP_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs1_tag(disp_rs1_tag),
      .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
      .disp_rob_idx(disp_rob_idx), .disp_rd_addr(disp_rd_addr),
      .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rob_idx(cdb_rob_idx),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rob_idx(issue_rob_idx), .issue_rd_addr(issue_rd_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          dv;
      logic [3:0]  op;
      bit          r1;
      logic [31:0] v1;
      logic [3:0]  t1;
      bit          r2;
      logic [31:0] v2;
      logic [3:0]  t2;
      logic [3:0]  rob;
      bit          cv;
      logic [31:0] cd;
      logic [3:0]  ci;
      bit          ir;
      bit          e_dr;
      bit          e_iv;
      logic [3:0]  e_op;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic [3:0]  e_rob;
   } vec_t;

   typedef struct {
      bit          busy;
      logic [3:0]  op;
      bit          r1;
      logic [31:0] v1;
      logic [3:0]  t1;
      bit          r2;
      logic [31:0] v2;
      logic [3:0]  t2;
      logic [3:0]  rob;
      logic [4:0]  rd;
   } ent_t;

   ent_t m [4];
   vec_t vecs [15];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_disp(bit dv, logic [3:0] op, bit r1, logic [31:0] v1, logic [3:0] t1,
                           bit r2, logic [31:0] v2, logic [3:0] t2, logic [3:0] rob);
      disp_valid   = dv;
      disp_op      = op;
      disp_rs1_rdy = r1;
      disp_rs1_val = v1;
      disp_rs1_tag = t1;
      disp_rs2_rdy = r2;
      disp_rs2_val = v2;
      disp_rs2_tag = t2;
      disp_rob_idx = rob;
      disp_rd_addr = {1'b1, rob};
   endtask

   task automatic set_cdb(bit cv, logic [31:0] cd, logic [3:0] ci);
      cdb_valid   = cv;
      cdb_data    = cd;
      cdb_rob_idx = ci;
   endtask

   task automatic idle();
      set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_cdb(0, 0, 0);
      issue_ready = 0;
      flush       = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 4; i++) m[i] = '{default: '0};
   endtask

   function automatic vec_t mk(bit dv, logic [3:0] op, bit r1, logic [31:0] v1, logic [3:0] t1,
                               bit r2, logic [31:0] v2, logic [3:0] t2, logic [3:0] rob,
                               bit cv, logic [31:0] cd, logic [3:0] ci, bit ir,
                               bit e_dr, bit e_iv, logic [3:0] e_op, logic [31:0] e_rs1,
                               logic [31:0] e_rs2, logic [3:0] e_rob);
      vec_t v;
      v.dv = dv; v.op = op; v.r1 = r1; v.v1 = v1; v.t1 = t1;
      v.r2 = r2; v.v2 = v2; v.t2 = t2; v.rob = rob;
      v.cv = cv; v.cd = cd; v.ci = ci; v.ir = ir;
      v.e_dr = e_dr; v.e_iv = e_iv; v.e_op = e_op;
      v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rob = e_rob;
      return v;
   endfunction

   // Reference model: one cycle of the station described by its entry list.
   task automatic rand_cycle();
      int sel = -1;
      int alloc = -1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (sel < 0 && m[i].busy && m[i].r1 && m[i].r2) sel = i;
         if (alloc < 0 && !m[i].busy) alloc = i;
      end
      chk("rand disp_ready", disp_ready, alloc >= 0);
      chk("rand issue_valid", issue_valid, sel >= 0);
      chk("rand issue_op", issue_op, sel >= 0 ? m[sel].op : 0);
      chk("rand issue_rs1", issue_rs1, sel >= 0 ? m[sel].v1 : 0);
      chk("rand issue_rs2", issue_rs2, sel >= 0 ? m[sel].v2 : 0);
      chk("rand issue_rob_idx", issue_rob_idx, sel >= 0 ? m[sel].rob : 0);
      chk("rand issue_rd_addr", issue_rd_addr, sel >= 0 ? m[sel].rd : 0);

      set_disp($urandom_range(0, 9) < 6, 4'($urandom), $urandom_range(0, 2) == 0, $urandom,
               4'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom,
               4'($urandom_range(0, 3)), 4'($urandom));
      disp_rd_addr = 5'($urandom);
      set_cdb($urandom_range(0, 1) == 1, $urandom, 4'($urandom_range(0, 3)));
      issue_ready = $urandom_range(0, 9) < 6;
      flush       = $urandom_range(0, 19) == 0;

      if (flush) begin
         for (int i = 0; i < 4; i++) m[i].busy = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m[i].busy && cdb_valid) begin
               if (!m[i].r1 && m[i].t1 == cdb_rob_idx) begin m[i].r1 = 1; m[i].v1 = cdb_data; end
               if (!m[i].r2 && m[i].t2 == cdb_rob_idx) begin m[i].r2 = 1; m[i].v2 = cdb_data; end
            end
         end
         if (sel >= 0 && issue_ready) m[sel].busy = 0;
         if (disp_valid && alloc >= 0) begin
            m[alloc].busy = 1;
            m[alloc].op   = disp_op;
            m[alloc].t1   = disp_rs1_tag;
            m[alloc].t2   = disp_rs2_tag;
            m[alloc].rob  = disp_rob_idx;
            m[alloc].rd   = disp_rd_addr;
            m[alloc].r1   = disp_rs1_rdy || (cdb_valid && cdb_rob_idx == disp_rs1_tag);
            m[alloc].v1   = (!disp_rs1_rdy && cdb_valid && cdb_rob_idx == disp_rs1_tag) ? cdb_data : disp_rs1_val;
            m[alloc].r2   = disp_rs2_rdy || (cdb_valid && cdb_rob_idx == disp_rs2_tag);
            m[alloc].v2   = (!disp_rs2_rdy && cdb_valid && cdb_rob_idx == disp_rs2_tag) ? cdb_data : disp_rs2_val;
         end
      end
      @(posedge clk);
   endtask

   initial begin
      vecs[0]  = mk(1, 3, 1, 32'h10, 0, 1, 32'h20, 0, 2,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  1, 1, 3, 32'h10, 32'h20, 2);
      vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 6, 0, 0, 5, 1, 32'h2, 0, 3,  0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h666, 6, 1,  1, 0, 0, 0, 0, 0);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'hDEADBEEF, 5, 1,  1, 0, 0, 0, 0, 0);
      vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  1, 1, 6, 32'hDEADBEEF, 32'h2, 3);
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[8]  = mk(1, 7, 0, 0, 7, 1, 32'h3, 0, 4,  1, 32'h1234, 7, 0,  1, 0, 0, 0, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  1, 1, 7, 32'h1234, 32'h3, 4);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[11] = mk(1, 9, 0, 0, 9, 0, 0, 9, 5,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'hA5A5A5A5, 9, 0,  1, 0, 0, 0, 0, 0);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  1, 1, 9, 32'hA5A5A5A5, 32'hA5A5A5A5, 5);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0);

      do_reset();
      chk("reset disp_ready", disp_ready, 1);
      chk("reset issue_valid", issue_valid, 0);
      chk("reset issue_rs1", issue_rs1, 0);
      chk("reset issue_rob_idx", issue_rob_idx, 0);

      // Directed vectors: outputs reflect state before this row's edge.
      for (int r = 0; r < 15; r++) begin
         @(negedge clk);
         set_disp(vecs[r].dv, vecs[r].op, vecs[r].r1, vecs[r].v1, vecs[r].t1,
                  vecs[r].r2, vecs[r].v2, vecs[r].t2, vecs[r].rob);
         set_cdb(vecs[r].cv, vecs[r].cd, vecs[r].ci);
         issue_ready = vecs[r].ir;
         chk($sformatf("vec%0d disp_ready", r), disp_ready, vecs[r].e_dr);
         chk($sformatf("vec%0d issue_valid", r), issue_valid, vecs[r].e_iv);
         chk($sformatf("vec%0d issue_op", r), issue_op, vecs[r].e_op);
         chk($sformatf("vec%0d issue_rs1", r), issue_rs1, vecs[r].e_rs1);
         chk($sformatf("vec%0d issue_rs2", r), issue_rs2, vecs[r].e_rs2);
         chk($sformatf("vec%0d issue_rob_idx", r), issue_rob_idx, vecs[r].e_rob);
         @(posedge clk);
      end

      // Fill all entries waiting on tag 1.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         idle();
         set_disp(1, 4'(k), 0, 0, 1, 1, 32'(k), 0, 4'(8 + k));
         @(posedge clk);
      end
      @(negedge clk);
      chk("full disp_ready", disp_ready, 0);
      chk("full issue_valid", issue_valid, 0);
      set_disp(1, 4'hF, 1, 32'hBAD, 0, 1, 32'hBAD, 0, 15);
      set_cdb(1, 32'h77, 1);
      @(posedge clk);
      @(negedge clk);
      idle();
      chk("wake all disp_ready", disp_ready, 0);
      chk("wake all issue_valid", issue_valid, 1);
      chk("wake lowest rob", issue_rob_idx, 8);
      chk("wake rs1", issue_rs1, 32'h77);
      issue_ready = 1;
      @(posedge clk);
      @(negedge clk);
      chk("after accept disp_ready", disp_ready, 1);
      chk("after accept rob", issue_rob_idx, 9);
      issue_ready = 1;
      set_disp(1, 4'hC, 1, 32'hC1, 0, 1, 32'hC2, 0, 12);
      @(posedge clk);
      @(negedge clk);
      idle();
      chk("reuse entry0 rob", issue_rob_idx, 12);
      chk("reuse entry0 rs1", issue_rs1, 32'hC1);
      chk("three busy disp_ready", disp_ready, 1);

      // Flush beats a simultaneous dispatch.
      flush = 1;
      set_disp(1, 4'hD, 1, 32'hD1, 0, 1, 32'hD2, 0, 13);
      @(posedge clk);
      @(negedge clk);
      idle();
      chk("flush issue_valid", issue_valid, 0);
      chk("flush disp_ready", disp_ready, 1);
      chk("flush issue_rob_idx", issue_rob_idx, 0);
      @(posedge clk);
      @(negedge clk);
      chk("flush no dispatch", issue_valid, 0);

      // Asynchronous reset in the middle of a cycle.
      for (int k = 1; k <= 3; k++) begin
         set_disp(1, 4'(k), 1, 32'(k), 0, 1, 32'(k), 0, 4'(k));
         @(posedge clk);
         @(negedge clk);
      end
      idle();
      chk("pre-reset issue_valid", issue_valid, 1);
      chk("pre-reset rob", issue_rob_idx, 1);
      #2 rst = 0;
      #1;
      chk("async reset issue_valid", issue_valid, 0);
      chk("async reset disp_ready", disp_ready, 1);
      chk("async reset issue_rs1", issue_rs1, 0);
      chk("async reset issue_rob_idx", issue_rob_idx, 0);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("post-reset issue_valid", issue_valid, 0);
      @(posedge clk);

      do_reset();
      for (int c = 0; c < 3000; c++) rand_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
